unidade_controle_multiciclo: RTL and testbench
==============================================

// Module: unidade_controle_multiciclo
// PURPOSE
//  Multicycle MIPS control FSM: the issuing end of the ULA interface. It decodes opcode/funct and drives
//  ALUControl, operand selects and datapath write enables. It consumes ULA zero for branches.
//  Sits between the instruction register and the datapath; one instruction completes every 3-5 cycles.
// PARAMETERS
//  STATE_W   4   state register width (12 states used)
// PORTS
//  clock        in   1  single system clock, rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  zero         in   1  ULA zero flag (combinational, same cycle)
//  ALUControl   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  alu_src_a    out  1  0=PC, 1=regA
//  alu_src_b    out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
//  pc_src       out  2  00=ULA result, 01=ALUOut, 10=jump target
//  pc_en        out  1  pc_write | (branch & taken)
//  iord         out  1  0=PC address, 1=ALUOut address
//  mem_write    out  1  data memory write strobe
//  ir_write     out  1  instruction register load
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=memory data
//  reg_write    out  1  register file write strobe
//  illegal_op   out  1  one-cycle pulse in DECODE for an unsupported opcode
// BEHAVIOUR
//  - Moore outputs decoded from the state register. The only Mealy term is pc_en in BRANCH, which uses zero.
//  - Reset: state<=FETCH on the edge. While reset=1, pc_en, mem_write, ir_write, reg_write and illegal_op
//    are forced to 0 combinationally. All other outputs are 0 and ALUControl=010.
//    A reset mid-instruction abandons it with no partial write after the reset edge.
//  - States/transitions:
//    FETCH:  iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, add, pc_src=00, pc_write -> DECODE
//    DECODE: alu_src_a=0, alu_src_b=11, add (branch target). Next state by opcode:
//            lw/sw(100011/101011) -> MEMADR; R(000000) -> EXECUTE; beq(000100) -> BRANCH;
//            addi(001000) -> ADDIEX; j(000010) -> JUMP; other -> FETCH with illegal_op=1
//    MEMADR: alu_src_a=1, alu_src_b=10, add -> MEMRD (lw) | MEMWR (sw)
//    MEMRD:  iord=1 -> MEMWB.   MEMWB: reg_dst=0, mem_to_reg=1, reg_write -> FETCH
//    MEMWR:  iord=1, mem_write -> FETCH
//    EXECUTE: alu_src_a=1, alu_src_b=00, ALUControl from funct -> ALUWB
//             (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other -> 010 and illegal_op=0)
//    ALUWB:  reg_dst=1, mem_to_reg=0, reg_write -> FETCH
//    BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero -> FETCH
//    ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB.   ADDIWB: reg_dst=0, reg_write -> FETCH
//    JUMP:   pc_src=10, pc_en=1 -> FETCH
//  - Latency (cycles): lw 5, sw/R/addi 4, beq/j 3, illegal 2. Unused state encodings recover to FETCH.
// CONFIGURATION
//  ULA_BNE_EN defined: bne (000101) DECODE -> BRANCH with sub; pc_en = ~zero for bne, zero for beq.
//    The opcode kind is registered in DECODE.
//  Undefined: 000101 is illegal (illegal_op pulse, back to FETCH); no extra flop.
// STRUCTURE
//  ula_defs.vh: ALUControl codes, opcode/funct constants, state encodings (`define/localparam).
//  Sub-module ula_decoder: combinational funct + alu_op[1:0] -> ALUControl. FSM emits alu_op.
// TESTING
//  1 reset=1 for 2 cycles mid-MEMWR -> mem_write=0 throughout; first cycle after release is FETCH with ir_write=1
//  2 opcode=000000, funct=100010 -> FETCH,DECODE,EXECUTE(ALUControl=110),ALUWB(reg_write=1,reg_dst=1); 4 cycles
//  3 opcode=100011 -> 5 cycles; MEMRD iord=1; MEMWB reg_write=1, mem_to_reg=1
//  4 beq: zero=1 in BRANCH -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; back to FETCH both times
//  5 opcode=111111 -> illegal_op=1 for exactly 1 cycle in DECODE, no write enables, FETCH next
//  6 (ULA_BNE_EN) opcode=000101, zero=0 -> pc_en=1; zero=1 -> pc_en=0; macro off -> illegal_op pulse

Source files
------------

// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the ULA operation codes, the opcode/funct constants, the state
// encodings and the control-word layout used by the FSM and the ALU decoder.
// Optional feature macro: ULA_BNE_EN (adds bne handling in DECODE/BRANCH).

package unidade_controle_multiciclo_pkg;

    localparam int STATE_BITS = 4;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Everything the FSM drives in one cycle; alu_op feeds the ALU decoder,
    // pc_write/branch are combined with the zero flag to form pc_en.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    // All-zero word: add on the ALU, PC source 00, no strobes.
    localparam ctrl_t CTRL_IDLE = '0;

    // True for every opcode this control unit knows how to sequence.
    function automatic logic isSupportedOpcode(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef ULA_BNE_EN
            OP_BNE: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_ula_decoder.sv
// ALU decoder for the multicycle control unit.
// Turns the FSM's two-bit ALU request plus the R-type funct field into the
// three-bit ALUControl code understood by the ULA.

module ula_decoder
    import unidade_controle_multiciclo_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Fixed add/sub requests pass straight through; R-type defers to funct,
    // and an unknown funct quietly falls back to add.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    default:   alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control FSM.
// Sequences FETCH/DECODE and the per-instruction states, driving operand
// selects and datapath write enables; pc_en in BRANCH is the only output
// that looks at the ULA zero flag. Optional macro ULA_BNE_EN adds bne, which
// needs one extra flop to remember the branch sense chosen in DECODE.

module unidade_controle_multiciclo
    import unidade_controle_multiciclo_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] ALUControl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;
    logic               branchTaken;

    // State register; reset lands on FETCH at the next edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ULA_BNE_EN
    logic is_bne_q;
    logic is_bne_d;

    // Remember in DECODE whether the branch is bne so BRANCH knows the sense.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_bne_q <= 1'b0;
        end else begin
            is_bne_q <= is_bne_d;
        end
    end

    // Capture the branch kind only while decoding; hold it otherwise.
    always_comb begin
        is_bne_d = is_bne_q;
        if (state_q == S_DECODE) begin
            is_bne_d = (opcode == OP_BNE);
        end
    end

    assign branchTaken = is_bne_q ? ~zero : zero;
`else
    assign branchTaken = zero;
`endif

    // Next-state logic; any unused encoding falls back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef ULA_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore control word per state; reset overrides everything to idle so
    // no strobe leaks out while an instruction is being abandoned.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctrl.iord      = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMMSH2;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~isSupportedOpcode(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_dst   = 1'b0;
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
        if (reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    ula_decoder u_ula_decoder (
        .alu_op_i      (ctrl.alu_op),
        .funct_i       (funct),
        .alu_control_o (ALUControl)
    );

    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign pc_en      = ctrl.pc_write | (ctrl.branch & branchTaken);
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for the multicycle MIPS control unit.
// Hand-written vectors, reset-abandon sequence and random instruction stream
// checked against an instruction-level model of each instruction's cycles.

module tb_unidade_controle_multiciclo;

    typedef struct packed {
        logic [2:0] aluc;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pe;
        logic       io;
        logic       mw;
        logic       iw;
        logic       rd;
        logic       mr;
        logic       rw;
        logic       il;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         step;
        int         len;
        exp_t       e;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] ALUControl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;

    int   checks;
    int   errors;
    bit   bneEnabled;
    exp_t expIdle;
    exp_t expFetch;
    vec_t vecs[$];

    unidade_controle_multiciclo #(.STATE_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .ALUControl (ALUControl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t mk(input logic [2:0] aluc, input logic sa, input logic [1:0] sb,
                                input logic [1:0] ps, input logic pe, input logic io,
                                input logic mw, input logic iw, input logic rd,
                                input logic mr, input logic rw, input logic il);
        exp_t e;
        e.aluc = aluc; e.sa = sa; e.sb = sb; e.ps = ps; e.pe = pe; e.io = io;
        e.mw = mw; e.iw = iw; e.rd = rd; e.mr = mr; e.rw = rw; e.il = il;
        return e;
    endfunction

    function automatic logic [2:0] functToAlu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic bit isKnown(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
            6'b000101: return bneEnabled;
            default:   return 1'b0;
        endcase
    endfunction

    // Cycles from FETCH until the next FETCH for one instruction.
    function automatic int modelLen(input logic [5:0] op);
        if (!isKnown(op)) return 2;
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            default: return 3;
        endcase
    endfunction

    // Expected outputs at a given cycle of one instruction.
    function automatic exp_t modelExp(input logic [5:0] op, input logic [5:0] fn,
                                      input int step, input logic z);
        exp_t e;
        e = expIdle;
        if (step == 0) return expFetch;
        if (step == 1) begin
            e.sb = 2'b11;
            e.il = !isKnown(op);
            return e;
        end
        case (op)
            6'b100011: begin
                if (step == 2) begin e.sa = 1; e.sb = 2'b10; end
                if (step == 3) e.io = 1;
                if (step == 4) begin e.mr = 1; e.rw = 1; end
            end
            6'b101011: begin
                if (step == 2) begin e.sa = 1; e.sb = 2'b10; end
                if (step == 3) begin e.io = 1; e.mw = 1; end
            end
            6'b000000: begin
                if (step == 2) begin e.sa = 1; e.sb = 2'b00; e.aluc = functToAlu(fn); end
                if (step == 3) begin e.rd = 1; e.rw = 1; end
            end
            6'b001000: begin
                if (step == 2) begin e.sa = 1; e.sb = 2'b10; end
                if (step == 3) e.rw = 1;
            end
            6'b000100, 6'b000101: begin
                e.sa = 1; e.aluc = 3'b110; e.ps = 2'b01;
                e.pe = (op == 6'b000100) ? z : ~z;
            end
            6'b000010: begin
                e.ps = 2'b10; e.pe = 1;
            end
            default: e = expIdle;
        endcase
        return e;
    endfunction

    // Drive one cycle's inputs at the falling edge and let them settle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rst);
        @(negedge clock);
        opcode = op;
        funct  = fn;
        zero   = z;
        reset  = rst;
        #1;
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        exp_t act;
        act = {ALUControl, alu_src_a, alu_src_b, pc_src, pc_en, iord, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, e);
        end
    endtask

    task automatic addVec(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int step, input int len, input exp_t e);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.z = z; v.step = step; v.len = len; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         len;

        checks = 0;
        errors = 0;
`ifdef ULA_BNE_EN
        bneEnabled = 1'b1;
`else
        bneEnabled = 1'b0;
`endif
        expIdle  = mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        expFetch = mk(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0);

        addVec("r_sub_execute", 6'b000000, 6'b100010, 0, 2, 4, mk(3'b110, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("r_sub_aluwb",   6'b000000, 6'b100010, 0, 3, 4, mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
        addVec("r_and_execute", 6'b000000, 6'b100100, 1, 2, 4, mk(3'b000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("r_slt_execute", 6'b000000, 6'b101010, 0, 2, 4, mk(3'b111, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("r_bad_funct",   6'b000000, 6'b000111, 0, 2, 4, mk(3'b010, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("lw_memrd",      6'b100011, 6'b000000, 0, 3, 5, mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
        addVec("lw_memwb",      6'b100011, 6'b000000, 0, 4, 5, mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0));
        addVec("sw_memwr",      6'b101011, 6'b000000, 0, 3, 4, mk(3'b010, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0));
        addVec("addi_wb",       6'b001000, 6'b000000, 0, 3, 4, mk(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
        addVec("beq_taken",     6'b000100, 6'b000000, 1, 2, 3, mk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
        addVec("beq_not_taken", 6'b000100, 6'b000000, 0, 2, 3, mk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
        addVec("j_jump",        6'b000010, 6'b000000, 0, 2, 3, mk(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        addVec("illegal_decode",6'b111111, 6'b000000, 0, 1, 2, mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
        addVec("lw_decode",     6'b100011, 6'b000000, 0, 1, 5, mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef ULA_BNE_EN
        addVec("bne_taken",     6'b000101, 6'b000000, 0, 2, 3, mk(3'b110, 1, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
        addVec("bne_not_taken", 6'b000101, 6'b000000, 1, 2, 3, mk(3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        addVec("bne_illegal",   6'b000101, 6'b000000, 0, 1, 2, mk(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

        // Power-up: two cycles in reset, everything idle with ALU on add.
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
        applyStimulus(6'b000000, 6'b000000, 0, 1);
        checkOutput("reset_hold_0", expIdle);
        applyStimulus(6'b000000, 6'b000000, 0, 1);
        checkOutput("reset_hold_1", expIdle);

        // Run sw up to MEMWR, then reset for two cycles in the middle of it.
        applyStimulus(6'b101011, 6'b000000, 0, 0);
        checkOutput("release_fetch", expFetch);
        for (int s = 1; s < 4; s++) begin
            applyStimulus(6'b101011, 6'b000000, 0, 0);
            checkOutput($sformatf("sw_pre_reset_s%0d", s), modelExp(6'b101011, 6'b000000, s, 0));
        end
        reset = 1'b1;
        #1;
        checkOutput("reset_in_memwr", expIdle);
        applyStimulus(6'b101011, 6'b000000, 0, 1);
        checkOutput("reset_memwr_cycle1", expIdle);
        applyStimulus(6'b101011, 6'b000000, 0, 1);
        checkOutput("reset_memwr_cycle2", expIdle);
        applyStimulus(6'b000000, 6'b100010, 0, 0);
        checkOutput("after_reset_fetch", expFetch);
        for (int s = 1; s < 4; s++) begin
            applyStimulus(6'b000000, 6'b100010, 0, 0);
            checkOutput($sformatf("r_sub_after_reset_s%0d", s), modelExp(6'b000000, 6'b100010, s, 0));
        end

        // Table of hand-computed vectors; every FETCH also checks the latency
        // of the instruction before it.
        for (int i = 0; i < vecs.size(); i++) begin
            for (int s = 0; s < vecs[i].len; s++) begin
                applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z, 0);
                if (s == 0) checkOutput({vecs[i].name, "_fetch"}, expFetch);
                else if (s == vecs[i].step) checkOutput(vecs[i].name, vecs[i].e);
            end
        end

        // Random instruction stream with zero toggling every cycle.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 8))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000101;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            len = modelLen(op);
            for (int s = 0; s < len; s++) begin
                z = 1'($urandom);
                applyStimulus(op, fn, z, 0);
                checkOutput($sformatf("rnd_op%b_s%0d", op, s), modelExp(op, fn, s, z));
            end
        end

        applyStimulus(6'b000000, 6'b000000, 0, 0);
        checkOutput("final_fetch", expFetch);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
